// File: rtl/spi_xor_receiver.sv
// spi_xor_receiver: mode-0 SPI slave that deserialises bytes in the clk domain.
// Data bytes are XOR-decrypted with key and written to a 16x8 display register
// at an auto-incrementing address. Command bytes (sent in clear) either clear
// the register and home the address (0x01) or set the address (0x8N).
module spi_xor_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_ce,
    input  logic       spi_data_in,
    input  logic       d_c,
    input  logic [7:0] key,
    output logic       ram_write_en,
    output logic [3:0] ram_W_A,
    output logic [7:0] ram_data,
    output logic       clr_lcd_reg,
    output logic       frame_err,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Synchronizer chains: index 0 takes the raw pin, top index is the safe copy.
    logic [SYNC_STAGES-1:0] sclk_q, sce_q, sdin_q, sdc_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, ce_s, din_s, dc_s, rise;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign ce_s   = sce_q[SYNC_STAGES-1];
    assign din_s  = sdin_q[SYNC_STAGES-1];
    assign dc_s   = sdc_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_q;

    // Synchronize the asynchronous SPI pins; reset loads their idle levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_q      <= '0;
            sce_q       <= '1;
            sdin_q      <= '0;
            sdc_q       <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            sce_q       <= {sce_q[SYNC_STAGES-2:0], spi_ce};
            sdin_q      <= {sdin_q[SYNC_STAGES-2:0], spi_data_in};
            sdc_q       <= {sdc_q[SYNC_STAGES-2:0], d_c};
            sclk_prev_q <= sclk_s;
        end
    end

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        dc_q, dc_d;
    logic [3:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wa_q, wa_d;
    logic [7:0]  data_q, data_d;
    logic        clr_q, clr_d;
    logic        ferr_q, ferr_d;
    logic        wrap_q, wrap_d;
    logic [7:0]  byte_nxt;

    assign byte_nxt = {shift_q[6:0], din_s};

    // State and output registers; strobes are registered so they land in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dc_q      <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            data_q    <= '0;
            clr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dc_q      <= dc_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            data_q    <= data_d;
            clr_q     <= clr_d;
            ferr_q    <= ferr_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state logic. Byte completion is decided on the 8th edge so the
    // write/clear strobes are valid during the single DONE cycle; the address
    // itself only moves on the edge that leaves DONE.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dc_d      = dc_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        wa_d      = wa_q;
        data_d    = data_q;
        clr_d     = 1'b0;
        ferr_d    = 1'b0;
        wrap_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ce_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                // Chip-enable release wins over a coincident clock edge.
                if (ce_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    ferr_d    = (bit_cnt_q != 3'd0);
                end else if (rise) begin
                    shift_d   = byte_nxt;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = DONE;
                        dc_d    = dc_s;
                        if (dc_s) begin
                            we_d   = 1'b1;
                            wa_d   = addr_q;
                            data_d = byte_nxt ^ key;
                            wrap_d = (addr_q == 4'hF);
                        end else if (byte_nxt == 8'h01) begin
                            clr_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d   = ce_s ? IDLE : SHIFT;
                bit_cnt_d = '0;
                if (dc_q)
                    addr_d = addr_q + 4'd1;
                else if (shift_q == 8'h01)
                    addr_d = '0;
                else if (shift_q[7:4] == 4'h8)
                    addr_d = shift_q[3:0];
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_write_en = we_q;
    assign ram_W_A      = wa_q;
    assign ram_data     = data_q;
    assign clr_lcd_reg  = clr_q;
    assign frame_err    = ferr_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_spi_xor_receiver.sv
// Self-checking bench for spi_xor_receiver: directed table, hand sequences for
// wrap/abort/reset corners, and randomized bytes against a behavioural model.
module tb_spi_xor_receiver;

    localparam int LAT = 3;  // SYNC_STAGES + 1 clk from driven edge to strobe

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_ce = 1'b1;
    logic       spi_data_in = 1'b0;
    logic       d_c = 1'b1;
    logic [7:0] key = 8'h00;
    logic       ram_write_en, clr_lcd_reg, frame_err, wrap;
    logic [3:0] ram_W_A;
    logic [7:0] ram_data;

    always #5 clk = ~clk;

    spi_xor_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_ce(spi_ce),
        .spi_data_in(spi_data_in), .d_c(d_c), .key(key),
        .ram_write_en(ram_write_en), .ram_W_A(ram_W_A), .ram_data(ram_data),
        .clr_lcd_reg(clr_lcd_reg), .frame_err(frame_err), .wrap(wrap)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output monitor: records strobes and counts protocol violations
    // (overlapping strobes, multi-cycle pulses, wrap without a write,
    // address/data changing outside a write).
    logic [3:0] wq_addr[$];
    logic [7:0] wq_data[$];
    bit         wq_wrap[$];
    int clr_cnt = 0, ferr_cnt = 0, wrap_cnt = 0, viol = 0;
    logic p_we = 0, p_clr = 0, p_ferr = 0, p_wrap = 0;
    logic [3:0] last_a = 0;
    logic [7:0] last_d = 0;

    always @(negedge clk) begin
        if (!reset) begin
            last_a = 0; last_d = 0;
            p_we = 0; p_clr = 0; p_ferr = 0; p_wrap = 0;
        end else begin
            if (ram_write_en) begin
                wq_addr.push_back(ram_W_A);
                wq_data.push_back(ram_data);
                wq_wrap.push_back(wrap);
                last_a = ram_W_A;
                last_d = ram_data;
            end else if (ram_W_A !== last_a || ram_data !== last_d) viol++;
            if (clr_lcd_reg) clr_cnt++;
            if (frame_err) ferr_cnt++;
            if (wrap) wrap_cnt++;
            if (int'(ram_write_en) + int'(clr_lcd_reg) + int'(frame_err) > 1) viol++;
            if (wrap && !ram_write_en) viol++;
            if ((ram_write_en && p_we) || (clr_lcd_reg && p_clr) ||
                (frame_err && p_ferr) || (wrap && p_wrap)) viol++;
            p_we = ram_write_en; p_clr = clr_lcd_reg; p_ferr = frame_err; p_wrap = wrap;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int last_lat;

    // Send the top n bits of b MSB first at clk/10 or slower; on each high
    // phase measure how many clk edges pass before a write/clear strobe.
    task automatic send_bits(input logic [7:0] b, input logic dcv, input int n);
        int lb;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_data_in = b[i];
            d_c = dcv;
            repeat (4) @(posedge clk);
            #1 spi_clk = 1'b1;
            lb = -1;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (lb < 0 && (ram_write_en || clr_lcd_reg)) lb = c;
            end
            last_lat = lb;
            spi_clk = 1'b0;
        end
    endtask

    task automatic begin_frame();
        @(posedge clk);
        #1 spi_ce = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic end_frame();
        repeat (2) @(posedge clk);
        #1 spi_ce = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0; spi_ce = 1'b1; spi_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Compare what the monitor saw since the snapshot against expectations.
    task automatic expect_byte(input string tag, input int wq0, input int clr0,
                               input int ferr0, input bit ew, input logic [3:0] ea,
                               input logic [7:0] ed, input bit ewrap, input bit eclr,
                               input bit eferr);
        check({tag, ".writes"}, wq_addr.size() - wq0, int'(ew));
        if (ew && wq_addr.size() > wq0) begin
            check({tag, ".addr"}, int'(wq_addr[wq0]), int'(ea));
            check({tag, ".data"}, int'(wq_data[wq0]), int'(ed));
            check({tag, ".wrap"}, int'(wq_wrap[wq0]), int'(ewrap));
        end
        check({tag, ".clr"}, clr_cnt - clr0, int'(eclr));
        check({tag, ".ferr"}, ferr_cnt - ferr0, int'(eferr));
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic [7:0] k;
        bit         w;
        logic [3:0] a;
        logic [7:0] d;
        bit         wr;
        bit         clr;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: the current write address.
    int m_addr;

    initial begin
        int wq0, c0, f0, w0, nb;
        logic [7:0] b, k;
        logic dcv;
        bit ew, ewr, ecl;
        logic [3:0] ea;
        logic [7:0] ed;

        vecs[0]  = '{1'b1, 8'h3C, 8'h5A, 1'b1, 4'h0, 8'h66, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h85, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, 8'h00, 1'b1, 4'h5, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h10, 8'h00, 1'b1, 4'h6, 8'h10, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h20, 8'h00, 1'b1, 4'h7, 8'h20, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h01, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h0F, 8'hA5, 1'b1, 4'h0, 8'hAA, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h42, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h33, 8'h00, 1'b1, 4'h1, 8'h33, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h8F, 8'hFF, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 8'hFF, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h01, 8'h00, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0};

        // Outputs held at zero during reset.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst.we",   int'(ram_write_en), 0);
        check("rst.addr", int'(ram_W_A), 0);
        check("rst.data", int'(ram_data), 0);
        check("rst.clr",  int'(clr_lcd_reg), 0);
        check("rst.ferr", int'(frame_err), 0);
        check("rst.wrap", int'(wrap), 0);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);

        // Directed table, all bytes in one frame.
        begin_frame();
        for (int i = 0; i < 12; i++) begin
            key = vecs[i].k;
            wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
            send_bits(vecs[i].b, vecs[i].dc, 8);
            repeat (2) @(posedge clk);
            expect_byte($sformatf("vec%0d", i), wq0, c0, f0, vecs[i].w, vecs[i].a,
                        vecs[i].d, vecs[i].wr, vecs[i].clr, 1'b0);
            if (vecs[i].dc) check($sformatf("vec%0d.lat", i), last_lat, LAT);
        end
        f0 = ferr_cnt;
        end_frame();
        check("clean_end.ferr", ferr_cnt - f0, 0);

        // Edges while chip enable is high are ignored.
        wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
        send_bits(8'hFF, 1'b1, 8);
        repeat (4) @(posedge clk);
        expect_byte("ce_high", wq0, c0, f0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 17 data bytes in one frame: addresses 0..15 then 0, wrap on 16th.
        do_reset();
        key = 8'h00;
        w0 = wrap_cnt;
        begin_frame();
        for (int i = 0; i < 17; i++) begin
            wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
            send_bits(8'(i + 8'h40), 1'b1, 8);
            repeat (2) @(posedge clk);
            expect_byte($sformatf("wrap%0d", i), wq0, c0, f0, 1'b1, 4'(i % 16),
                        8'(i + 8'h40), (i == 15), 1'b0, 1'b0);
        end
        end_frame();
        check("wrap.count", wrap_cnt - w0, 1);

        // Abort after 5 bits: one frame_err, no write, address stays at 1.
        wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
        begin_frame();
        send_bits(8'hAB, 1'b1, 5);
        repeat (2) @(posedge clk);
        #1 spi_ce = 1'b1;
        repeat (8) @(posedge clk);
        expect_byte("abort", wq0, c0, f0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
        begin_frame();
        send_bits(8'h5C, 1'b1, 8);
        end_frame();
        expect_byte("after_abort", wq0, c0, f0, 1'b1, 4'h1, 8'h5C, 1'b0, 1'b0, 1'b0);

        // Reset mid-byte: no frame_err, first byte afterwards goes to address 0.
        wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
        begin_frame();
        send_bits(8'hF0, 1'b1, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        send_bits(8'h12, 1'b1, 8);
        end_frame();
        expect_byte("rst_mid", wq0, c0, f0, 1'b1, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0);

        // Randomized bytes and aborts against the reference model.
        do_reset();
        m_addr = 0;
        begin_frame();
        for (int t = 0; t < 40; t++) begin
            wq0 = wq_addr.size(); c0 = clr_cnt; f0 = ferr_cnt;
            if ($urandom_range(0, 9) == 0) begin
                nb = $urandom_range(1, 7);
                send_bits(8'($urandom), 1'($urandom), nb);
                repeat (2) @(posedge clk);
                #1 spi_ce = 1'b1;
                repeat (8) @(posedge clk);
                expect_byte($sformatf("rnd%0d.abort", t), wq0, c0, f0, 1'b0, 4'h0,
                            8'h00, 1'b0, 1'b0, 1'b1);
                begin_frame();
            end else begin
                dcv = 1'($urandom_range(0, 1));
                k = 8'($urandom);
                case ($urandom_range(0, 2))
                    0: b = 8'h01;
                    1: b = {4'h8, 4'($urandom)};
                    default: b = 8'($urandom);
                endcase
                if (dcv) b = 8'($urandom);
                ew = 0; ewr = 0; ecl = 0; ea = 0; ed = 0;
                if (dcv) begin
                    ew = 1; ea = 4'(m_addr); ed = b ^ k; ewr = (m_addr == 15);
                    m_addr = (m_addr + 1) % 16;
                end else if (b == 8'h01) begin
                    ecl = 1; m_addr = 0;
                end else if (b / 16 == 8) begin
                    m_addr = b % 16;
                end
                key = k;
                send_bits(b, dcv, 8);
                repeat (2) @(posedge clk);
                expect_byte($sformatf("rnd%0d", t), wq0, c0, f0, ew, ea, ed, ewr, ecl, 1'b0);
            end
        end
        end_frame();

        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
